// File: rtl/masked_stage2_random_gen_pkg.sv
// Shared definitions for the stage-2 masked randomness generator.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package aes128_package;

  // Randomness source geometry: 64-bit Fibonacci LFSR with taps 63/62/60/59.
  localparam int LFSR_W     = 64;
  localparam int LFSR_TAP_A = 63;
  localparam int LFSR_TAP_B = 62;
  localparam int LFSR_TAP_C = 60;
  localparam int LFSR_TAP_D = 59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rng_state_t;

  // Masking gadget family of the consuming inverse.
  typedef enum logic {
    HPC3 = 1'b0
  } masking_t;

  // Number of distinct share pairs, i.e. cross-domain terms per AND gadget.
  function automatic int num_quad(input int shares);
    return (shares * (shares - 1)) / 2;
  endfunction

  // Fresh random bits consumed per evaluation of the stage-2 inverse.
  function automatic int stage_2_randoms(input int shares, input masking_t scheme);
    return (scheme == HPC3) ? 14 * num_quad(shares) : 0;
  endfunction

endpackage

// File: rtl/masked_stage2_random_gen_lfsr.sv
// Purpose: STEPS consecutive Fibonacci LFSR steps unrolled into one combinational stage.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
// Ports: state_in  - current 64-bit LFSR state
//        state_out - state after STEPS single-bit steps
module lfsr64_multistep
  import aes128_package::*;
#(
  parameter int STEPS = 14
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out
);

  logic [LFSR_W-1:0] step_s;

  always_comb begin
    step_s = state_in;
    for (int i = 0; i < STEPS; i++) begin
      step_s = {step_s[LFSR_W-2:0],
                step_s[LFSR_TAP_A] ^ step_s[LFSR_TAP_B] ^ step_s[LFSR_TAP_C] ^ step_s[LFSR_TAP_D]};
    end
    state_out = step_s;
  end

endmodule

// File: rtl/masked_stage2_random_gen.sv
// Purpose: seeded LFSR randomness source feeding a masked stage-2 HPC3 inverse.
// Latency: WARMUP_CYCLES+1 cycles from seed handshake to first valid word; one word per cycle after.
// Backpressure: out_random holds while in_ready is low; seeds only accepted in IDLE/RUN.
// Ports: in_clock/in_reset (async, active-low); in_seed/in_seed_valid/out_seed_ready seed channel;
//        out_seed_zero pulses when an all-zero seed is refused; out_random/out_valid/in_ready
//        output channel carrying {left_p, right_p, theta_p, joint_r}.
module masked_stage2_random_gen
  import aes128_package::*;
#(
  parameter int          NUM_SHARES      = 2,
  parameter int          WARMUP_CYCLES   = 16,
  parameter logic [31:0] RESEED_INTERVAL = 32'h0010_0000,
  localparam int         NUM_QUARDATIC   = num_quad(NUM_SHARES),
  localparam int         NUM_RANDOM      = stage_2_randoms(NUM_SHARES, HPC3)
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic [63:0]           in_seed,
  input  logic                  in_seed_valid,
  output logic                  out_seed_ready,
  output logic                  out_seed_zero,
  output logic [NUM_RANDOM-1:0] out_random,
  output logic                  out_valid,
  input  logic                  in_ready
);

  // Elaboration-time sanity checks: the word is cut from the LFSR state.
  if (NUM_RANDOM < 1 || NUM_RANDOM > LFSR_W || NUM_RANDOM != 14 * NUM_QUARDATIC) begin : g_bad_width
    $error("masked_stage2_random_gen: NUM_RANDOM out of range 1..64");
  end
  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
    $error("masked_stage2_random_gen: WARMUP_CYCLES out of range 1..255");
  end

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  rng_state_t        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [7:0]        warm_cnt_q, warm_cnt_d;
  logic [31:0]       use_cnt_q, use_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              seed_ready_q, seed_ready_d;
  logic              seed_zero_q, seed_zero_d;

  logic seed_hs;
  logic seed_load;
  logic out_hs;

  lfsr64_multistep #(
    .STEPS (NUM_RANDOM)
  ) u_adv (
    .state_in  (lfsr_q),
    .state_out (lfsr_adv)
  );

  assign seed_hs   = in_seed_valid && seed_ready_q;
  // A zero seed would lock the LFSR at zero forever, so it is refused outright.
  assign seed_load = seed_hs && (in_seed != 64'd0);
  assign out_hs    = in_ready && out_valid_q;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    warm_cnt_d  = warm_cnt_q;
    use_cnt_d   = use_cnt_q;
    seed_zero_d = seed_hs && (in_seed == 64'd0);

    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d     = in_seed;
          warm_cnt_d = 8'd0;
          use_cnt_d  = 32'd0;
          state_d    = WARMUP;
        end
      end
      WARMUP: begin
        lfsr_d     = lfsr_adv;
        warm_cnt_d = warm_cnt_q + 8'd1;
        if (warm_cnt_q == WARM_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_hs) begin
          lfsr_d    = lfsr_adv;
          use_cnt_d = use_cnt_q + 32'd1;
          if (use_cnt_q + 32'd1 == RESEED_INTERVAL) begin
            state_d = IDLE;
          end
        end
        // A reseed overrides both the advance and the interval expiry; the
        // word presented this cycle is still handed to the consumer.
        if (seed_load) begin
          lfsr_d     = in_seed;
          warm_cnt_d = 8'd0;
          use_cnt_d  = 32'd0;
          state_d    = WARMUP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered off the next state.
    out_valid_d  = (state_d == RUN);
    seed_ready_d = (state_d != WARMUP);
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q      <= IDLE;
      lfsr_q       <= '0;
      warm_cnt_q   <= 8'd0;
      use_cnt_q    <= 32'd0;
      out_valid_q  <= 1'b0;
      seed_ready_q <= 1'b1;
      seed_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      warm_cnt_q   <= warm_cnt_d;
      use_cnt_q    <= use_cnt_d;
      out_valid_q  <= out_valid_d;
      seed_ready_q <= seed_ready_d;
      seed_zero_q  <= seed_zero_d;
    end
  end

  assign out_random     = lfsr_q[NUM_RANDOM-1:0];
  assign out_valid      = out_valid_q;
  assign out_seed_ready = seed_ready_q;
  assign out_seed_zero  = seed_zero_q;

endmodule
